fp8_dot_acc: RTL and testbench

//  Streaming accumulator directly downstream of the FP8 E4M3 multiplier: sums a vector of FP8 products exactly.

---
 rtl/fp8_dot_acc.sv | 145 ++++++++++++++
 tb/tb_fp8_dot_acc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_dot_acc.sv
// Exact fixed-point accumulator for streams of FP8 E4M3 products. Each vector's sum
// is rounded once to FP8 (round to nearest even) and held on a ready/valid output port.
module fp8_dot_acc #(
  parameter int ACC_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_flags
);

  typedef enum logic [1:0] {ST_ACC, ST_NORM, ST_OUT} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_nan, r_sat;
  logic [7:0]         r_out_data;
  logic [1:0]         r_out_flags;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_nxt = ST_NORM;
      end
      ST_NORM: w_state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_ACC;
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACC;
    else     r_state <= w_state_nxt;
  end

  // Element decode: magnitude in units of 2^-9
  logic [3:0]   w_exp;
  logic         w_in_nan;
  logic [16:0]  w_mag;
  logic [ACC_W:0] w_acc_ext, w_mag_ext, w_sum;
  logic         w_ovf;
  logic [ACC_W-1:0] w_acc_nxt;

  always_comb begin
    w_exp    = in_data[6:3];
    w_in_nan = &w_exp;
    if (w_exp == 4'd0) w_mag = {14'd0, in_data[2:0]};
    else               w_mag = {13'd0, 1'b1, in_data[2:0]} << (w_exp - 4'd1);
    w_acc_ext = {r_acc[ACC_W-1], r_acc};
    w_mag_ext = {{(ACC_W-16){1'b0}}, w_mag};
    w_sum     = in_data[7] ? (w_acc_ext - w_mag_ext) : (w_acc_ext + w_mag_ext);
    w_ovf     = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    if (w_ovf) w_acc_nxt = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    else       w_acc_nxt = w_sum[ACC_W-1:0];
  end

  // Conversion of the final accumulator to FP8
  logic             w_neg;
  logic [ACC_W-1:0] w_m, w_norm;
  logic [7:0]       w_p, w_shamt, w_bexp;
  logic [2:0]       w_mant3, w_mant_r;
  logic             w_guard, w_sticky, w_rnd, w_carry;
  logic [7:0]       w_cvt_data;
  logic [1:0]       w_cvt_flags;

  always_comb begin
    w_neg = r_acc[ACC_W-1];
    w_m   = w_neg ? ('0 - r_acc) : r_acc;
    w_p   = '0;
    for (int unsigned i = 0; i < ACC_W; i++) begin
      if (w_m[i]) w_p = 8'(i);
    end
    // Shift the leading one out the top so the remaining bits are mantissa, guard, sticky
    w_shamt  = 8'(ACC_W) - w_p;
    w_norm   = w_m << w_shamt;
    w_mant3  = w_norm[ACC_W-1 -: 3];
    w_guard  = w_norm[ACC_W-4];
    w_sticky = |w_norm[ACC_W-5:0];
    w_rnd    = w_guard & (w_sticky | w_mant3[0]);
    {w_carry, w_mant_r} = {1'b0, w_mant3} + {3'd0, w_rnd};
    w_bexp   = w_p - 8'd2 + {7'd0, w_carry};

    w_cvt_data  = 8'h00;
    w_cvt_flags = 2'b00;
    if (r_nan) begin
      w_cvt_data  = 8'h7F;
      w_cvt_flags = 2'b10;
    end else if (r_sat || ((|w_m[ACC_W-1:3]) && (w_bexp > 8'd14))) begin
      w_cvt_data  = {w_neg, 7'h77};
      w_cvt_flags = 2'b01;
    end else if (~|w_m) begin
      w_cvt_data = 8'h00;
    end else if (~|w_m[ACC_W-1:3]) begin
      w_cvt_data = {w_neg, 4'h0, w_m[2:0]};
    end else begin
      w_cvt_data = {w_neg, w_bexp[3:0], w_mant_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_nan       <= 1'b0;
      r_sat       <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else begin
      if (r_state == ST_ACC && in_valid) begin
        if (w_in_nan) begin
          r_nan <= 1'b1;
        end else begin
          r_acc <= w_acc_nxt;
          if (w_ovf) r_sat <= 1'b1;
        end
      end else if (r_state == ST_NORM) begin
        r_out_data  <= w_cvt_data;
        r_out_flags <= w_cvt_flags;
      end else if (r_state == ST_OUT && out_ready) begin
        r_acc <= '0;
        r_nan <= 1'b0;
        r_sat <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fp8_dot_acc.sv
// Bench for fp8_dot_acc: directed vector table, handshake/reset sequences,
// and random vectors checked against a value-level rounding model.
module tb_fp8_dot_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [1:0] out_flags;

  fp8_dot_acc #(.ACC_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    int         n;
    logic [7:0] e0, e1, e2;
    logic [7:0] d;
    logic [1:0] f;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] vec[$];

  localparam longint ACC_MAX = (64'sd1 <<< 31) - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Value of a finite code in units of 2^-9 (sign included)
  function automatic longint val_of(input logic [7:0] c);
    longint mag;
    if (c[6:3] == 4'd0) mag = longint'(c[2:0]);
    else                mag = (8 + longint'(c[2:0])) * (64'sd1 <<< (int'(c[6:3]) - 1));
    return c[7] ? -mag : mag;
  endfunction

  task automatic ref_result(output logic [7:0] d, output logic [1:0] f);
    longint sum = 0, mag, dlo, dhi;
    bit nan = 0, sat = 0, s;
    logic [7:0] lo, pick;
    foreach (vec[i]) begin
      if (vec[i][6:3] == 4'hF) nan = 1;
      else begin
        sum += val_of(vec[i]);
        if (sum > ACC_MAX)       begin sum = ACC_MAX;  sat = 1; end
        else if (sum < -ACC_MAX) begin sum = -ACC_MAX; sat = 1; end
      end
    end
    s   = (sum < 0);
    mag = s ? -sum : sum;
    if (nan) begin d = 8'h7F; f = 2'b10; return; end
    if (sat) begin d = {s, 7'h77}; f = 2'b01; return; end
    if (mag == 0) begin d = 8'h00; f = 2'b00; return; end
    // nearest positive code, 0x78 standing in for 256.0 (first out-of-range value)
    lo = 8'h00;
    for (int c = 0; c <= 8'h78; c++)
      if (val_of(8'(c)) <= mag) lo = 8'(c);
    if (lo == 8'h78) pick = 8'h78;
    else begin
      dlo = mag - val_of(lo);
      dhi = val_of(lo + 8'd1) - mag;
      if (dlo < dhi)      pick = lo;
      else if (dhi < dlo) pick = lo + 8'd1;
      else                pick = lo[0] ? lo + 8'd1 : lo;
    end
    if (pick == 8'h78) begin d = {s, 7'h77}; f = 2'b01; end
    else               begin d = {s, pick[6:0]}; f = 2'b00; end
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_vec();
    foreach (vec[i]) put(vec[i], (i == vec.size() - 1));
  endtask

  task automatic get_res(input int stall, output logic [7:0] d, output logic [1:0] f);
    int guard = 0;
    d = 8'hxx; f = 2'bxx;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!out_valid) begin chk("out_valid_timeout", 0, 1); return; end
    repeat (stall) begin @(posedge clk); #1; end
    d = out_data; f = out_flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic add(input string nm, input int n, input logic [7:0] a0, a1, a2,
                     input logic [7:0] d, input logic [1:0] f);
    vec_t v;
    v.name = nm; v.n = n; v.e0 = a0; v.e1 = a1; v.e2 = a2; v.d = d; v.f = f;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] d, ed;
    logic [1:0] f, ef;
    int guard;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    add("single",      1, 8'h38, 8'h00, 8'h00, 8'h38, 2'b00);
    add("three_ones",  3, 8'h38, 8'h38, 8'h38, 8'h44, 2'b00);
    add("cancel",      2, 8'h38, 8'hB8, 8'h00, 8'h00, 2'b00);
    add("tie_even",    2, 8'h38, 8'h18, 8'h00, 8'h38, 2'b00);
    add("tie_up",      2, 8'h39, 8'h18, 8'h00, 8'h3A, 2'b00);
    add("subnormal",   2, 8'h01, 8'h01, 8'h00, 8'h02, 2'b00);
    add("neg_sub",     3, 8'h80, 8'h81, 8'h82, 8'h83, 2'b00);
    add("neg_zero",    1, 8'h80, 8'h00, 8'h00, 8'h00, 2'b00);
    add("sat_pos",     2, 8'h77, 8'h77, 8'h00, 8'h77, 2'b01);
    add("sat_neg",     2, 8'hF7, 8'hF7, 8'h00, 8'hF7, 2'b01);
    add("round_sat",   2, 8'h77, 8'h50, 8'h00, 8'h77, 2'b01);
    add("nan_mix",     3, 8'h38, 8'h7F, 8'hF7, 8'h7F, 2'b10);
    add("nan_noncan",  1, 8'hF9, 8'h00, 8'h00, 8'h7F, 2'b10);
    add("nan_over_sat",3, 8'h77, 8'h77, 8'hFF, 8'h7F, 2'b10);

    #3;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  8'h00);
    chk("rst_out_flags", out_flags, 2'b00);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // latency of a one-element vector
    put(8'h38, 1'b1);
    chk("lat_norm_valid", out_valid, 0);
    chk("lat_norm_ready", in_ready,  0);
    @(posedge clk); #1;
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_data",  out_data,  8'h38);
    chk("lat_out_flags", out_flags, 2'b00);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("lat_release_valid", out_valid, 0);
    chk("lat_release_ready", in_ready,  1);

    foreach (tbl[k]) begin
      vec.delete();
      vec.push_back(tbl[k].e0);
      if (tbl[k].n > 1) vec.push_back(tbl[k].e1);
      if (tbl[k].n > 2) vec.push_back(tbl[k].e2);
      send_vec();
      get_res(k % 3, d, f);
      chk({tbl[k].name, "_data"},  d, tbl[k].d);
      chk({tbl[k].name, "_flags"}, f, tbl[k].f);
    end

    // backpressure with a waiting producer, then no-bypass restart
    vec.delete(); vec.push_back(8'h39); vec.push_back(8'h18);
    send_vec();
    guard = 0;
    while (!out_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1; in_data = 8'h38; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_in_ready",  in_ready,  0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data",  out_data,  8'h3A);
      chk("bp_out_flags", out_flags, 2'b00);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_after_hs_valid", out_valid, 0);
    chk("bp_after_hs_ready", in_ready,  1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_norm", in_ready, 0);
    get_res(0, d, f);
    chk("bp_next_data",  d, 8'h38);
    chk("bp_next_flags", f, 2'b00);

    // reset mid-vector
    put(8'h40, 1'b0);
    put(8'h40, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_in_ready",  in_ready,  1);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_out_data",  out_data,  8'h00);
    chk("rstmid_out_flags", out_flags, 2'b00);
    @(posedge clk); #1; rst = 1'b0;
    put(8'h38, 1'b1);
    get_res(0, d, f);
    chk("rstmid_next_data",  d, 8'h38);
    chk("rstmid_next_flags", f, 2'b00);

    // reset while a result is pending
    put(8'h44, 1'b1);
    @(posedge clk); #1;
    chk("rstout_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstout_valid", out_valid, 0);
    chk("rstout_data",  out_data,  8'h00);
    @(posedge clk); #1; rst = 1'b0;

    // random vectors against the reference model
    for (int t = 0; t < 60; t++) begin
      int len = $urandom_range(1, 8);
      vec.delete();
      for (int i = 0; i < len; i++) begin
        logic [7:0] c;
        c[7]   = 1'($urandom_range(0, 1));
        c[2:0] = 3'($urandom_range(0, 7));
        c[6:3] = ($urandom_range(0, 11) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        vec.push_back(c);
      end
      ref_result(ed, ef);
      send_vec();
      get_res($urandom_range(0, 2), d, f);
      chk($sformatf("rand%0d_data", t),  d, ed);
      chk($sformatf("rand%0d_flags", t), f, ef);
    end

    // accumulator overflow: 17480 * 240 exceeds the 32-bit range
    vec.delete();
    for (int i = 0; i < 17480; i++) vec.push_back(8'h77);
    ref_result(ed, ef);
    send_vec();
    get_res(0, d, f);
    chk("ovf_data",  d, 8'h77);
    chk("ovf_flags", f, 2'b01);
    chk("ovf_model_data", d, ed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
